// File: rtl/spi_slave_regs_if.sv
// SPI bus between an SPI master and the spi_slave_regs register block.
// The master drives sclk, cs (active low) and mosi; the slave drives miso.
interface spi_slave_regs_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a four-entry byte register file.
// Frame: command byte {rw, 5'bx, addr[1:0]} followed by one data byte.
// Registers 0..2 are read/write; register 3 is the read-only ID_BYTE.
// All SPI inputs are resynchronised into the clk domain before use.
module spi_slave_regs #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_regs_if.slave      spi,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic [31:0]          reg_out,
  output logic                 frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  // Synchroniser chains; fill_q marks when the chains hold sampled data
  // rather than their reset values.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
  logic                   sclk_s, cs_s, mosi_s, sync_live;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        armed_q, armed_d;
  logic        miso_q, miso_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  regs_q [3];
  logic [7:0]  regs_d [3];

  logic [7:0]  shift_q, shift_d, shift_next;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [1:0]  addr_q, addr_d;
  logic        first_fall_q, first_fall_d;

  // Register 3 is a constant; the others come from the register file.
  function automatic logic [7:0] read_reg(input logic [1:0] a,
                                          input logic [7:0] r0,
                                          input logic [7:0] r1,
                                          input logic [7:0] r2);
    case (a)
      2'd0:    read_reg = r0;
      2'd1:    read_reg = r1;
      2'd2:    read_reg = r2;
      default: read_reg = ID_BYTE;
    endcase
  endfunction

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sync_live  = fill_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d1_q;
  assign sclk_fall  = ~sclk_s & sclk_d1_q;
  assign cs_fall    = cs_d1_q & ~cs_s;
  assign shift_next = {shift_q[6:0], mosi_s};

  assign spi.miso  = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign reg_out   = {ID_BYTE, regs_q[2], regs_q[1], regs_q[0]};

  // Synchronisers, edge-detect delays and all control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      regs_q[0]   <= 8'h00;
      regs_q[1]   <= 8'h00;
      regs_q[2]   <= 8'h00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d1_q   <= sclk_s;
      cs_d1_q     <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  // Datapath registers that are always loaded before they are consumed.
  always_ff @(posedge clk) begin
    shift_q      <= shift_d;
    tx_q         <= tx_d;
    rw_q         <= rw_d;
    addr_q       <= addr_d;
    first_fall_q <= first_fall_d;
  end

  // Frame sequencing: cs high overrides everything, then per-state edges.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    miso_d       = miso_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = frame_err_q;
    regs_d       = regs_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    first_fall_d = first_fall_q;
    // Reset-valued synchroniser contents must not count as "cs seen high".
    armed_d      = armed_q | (cs_s & sync_live);

    if (cs_s) begin
      // cs deasserted: abort any frame; a same-cycle sclk rise is dropped.
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      if (state_q == CMD || state_q == DATA)
        frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall && armed_q) begin
            state_d     = CMD;
            bit_cnt_d   = 3'd0;
            miso_d      = 1'b0;
            frame_err_d = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d         = shift_next[7];
              addr_d       = shift_next[1:0];
              rx_valid_d   = 1'b1;
              rx_data_d    = shift_next;
              first_fall_d = 1'b1;
              state_d      = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_next;
              miso_d     = 1'b0;
              state_d    = DONE;
              if (rw_q && addr_q != 2'd3)
                regs_d[addr_q] = shift_next;
            end
          end else if (sclk_fall) begin
            // First fall loads the read byte; later falls shift it out MSB first.
            if (first_fall_q) begin
              tx_d         = rw_q ? 8'h00
                                  : read_reg(addr_q, regs_q[0], regs_q[1], regs_q[2]);
              first_fall_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
            miso_d = tx_d[7];
          end
        end
        DONE: begin
          if (sclk_rise)
            frame_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
